seq_divider_r2: RTL and testbench

//  Sequential unsigned radix-2 restoring divider. It is the responder side of the

---
 rtl/seq_divider_r2.sv | 113 +++++++++++
 tb/tb_seq_divider_r2.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_r2.sv
// Unsigned radix-2 restoring divider, one quotient bit per cycle.
// Responder for the start/busy/done/valid/dbz divide handshake.
module seq_divider_r2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             valid_o,
    output logic             dbz_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] reminder_o
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] rem_acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] dvsr;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   shift;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] q_nx;
    logic [WIDTH-1:0] rem_nx;
    logic             last;

    assign dbz_o  = (divisor_i == '0);
    assign busy_o = (state != IDLE);
    assign done_o = (state == DONE);

    // The partial remainder stays below the divisor, so its top bit is never
    // stored; the subtract still runs WIDTH+1 bits wide for large divisors.
    always_comb begin
        shift  = {rem_acc, q[WIDTH-1]};
        diff   = shift - {1'b0, dvsr};
        q_nx   = {q[WIDTH-2:0], ~diff[WIDTH]};
        rem_nx = diff[WIDTH] ? shift[WIDTH-1:0] : diff[WIDTH-1:0];
        last   = (cnt == CW'(1));
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start_i)
                    state_nx = dbz_o ? DONE : CALC;
            end
            CALC: begin
                if (last)
                    state_nx = DONE;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            rem_acc    <= '0;
            q          <= '0;
            dvsr       <= '0;
            cnt        <= '0;
            valid_o    <= 1'b0;
            quotient_o <= '0;
            reminder_o <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        // Divide by zero goes straight to DONE with a valid result.
                        if (dbz_o) begin
                            valid_o    <= 1'b1;
                            quotient_o <= '1;
                            reminder_o <= dividend_i;
                        end else begin
                            valid_o <= 1'b0;
                            q       <= dividend_i;
                            dvsr    <= divisor_i;
                            rem_acc <= '0;
                            cnt     <= CW'(WIDTH);
                        end
                    end
                end
                CALC: begin
                    q       <= q_nx;
                    rem_acc <= rem_nx;
                    cnt     <= cnt - CW'(1);
                    if (last) begin
                        valid_o    <= 1'b1;
                        quotient_o <= q_nx;
                        reminder_o <= rem_nx;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_r2.sv
// Directed and model-based checks for seq_divider_r2 (WIDTH=32).
module tb_seq_divider_r2;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic         valid;
    logic         dbz;
    logic [W-1:0] quotient;
    logic [W-1:0] reminder;

    int checks = 0;
    int errors = 0;

    seq_divider_r2 #(.WIDTH(W)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .dividend_i (dividend),
        .divisor_i  (divisor),
        .busy_o     (busy),
        .done_o     (done),
        .valid_o    (valid),
        .dbz_o      (dbz),
        .quotient_o (quotient),
        .reminder_o (reminder)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive a request and return 1 time unit after the accepting edge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges until done is seen; busy must stay high meanwhile.
    task automatic wait_done(input string tag, input int exp_lat);
        int k = 0;
        while (done !== 1'b1 && k < 200) begin
            if (busy !== 1'b1)
                check({tag, "_busy"}, {63'd0, busy}, 64'd1);
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, "_lat"}, 64'(k), 64'(exp_lat));
        check({tag, "_busy_done"}, {63'd0, busy}, 64'd1);
        check({tag, "_valid"}, {63'd0, valid}, 64'd1);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a,
                          input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er);
        launch(a, b);
        wait_done(tag, (b == 0) ? 0 : W);
        check({tag, "_q"}, 64'(quotient), 64'(eq));
        check({tag, "_r"}, 64'(reminder), 64'(er));
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
        check({tag, "_idle"}, {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;
        check({tag, "_hold_q"}, 64'(quotient), 64'(eq));
        check({tag, "_hold_r"}, 64'(reminder), 64'(er));
        check({tag, "_hold_v"}, {63'd0, valid}, 64'd1);
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] eq;
        logic [W-1:0] er;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = 32'd1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_valid", {63'd0, valid}, 64'd0);
        check("rst_q", 64'(quotient), 64'd0);
        check("rst_r", 64'(reminder), 64'd0);

        run_op("d100_7", 32'd100, 32'd7, 32'd14, 32'd2);
        run_op("dmax_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
        run_op("d5_big", 32'd5, 32'h8000_0000, 32'd0, 32'd5);
        run_op("dhalf_max", 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        run_op("dmax_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0);

        // dbz is combinational from the divisor input
        divisor = '0;
        #1;
        check("dbz_zero", {63'd0, dbz}, 64'd1);
        divisor = 32'd3;
        #1;
        check("dbz_nonzero", {63'd0, dbz}, 64'd0);
        run_op("dbz_op", 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234);

        // start while busy is ignored; start held through DONE waits for IDLE
        launch(32'd100, 32'd7);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("busy_ign", W - 5);
        check("busy_ign_q", 64'(quotient), 64'd14);
        check("busy_ign_r", 64'(reminder), 64'd2);
        start = 1'b1;
        @(posedge clk);
        #1;
        check("done_ign_busy", {63'd0, busy}, 64'd0);
        check("done_ign_done", {63'd0, done}, 64'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("acc_after_done", {63'd0, busy}, 64'd1);
        check("acc_valid_clr", {63'd0, valid}, 64'd0);
        wait_done("d9_3", W);
        check("d9_3_q", 64'(quotient), 64'd3);
        check("d9_3_r", 64'(reminder), 64'd0);
        @(posedge clk);
        #1;

        // asynchronous reset mid-operation
        launch(32'd100, 32'd7);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_valid", {63'd0, valid}, 64'd0);
        check("arst_q", 64'(quotient), 64'd0);
        check("arst_r", 64'(reminder), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_op("d20_6", 32'd20, 32'd6, 32'd3, 32'd2);

        for (int i = 0; i < 150; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 5 == 1) b = b >> $urandom_range(31, 8);
            if (i % 17 == 3) b = '0;
            if (b == 0) begin
                eq = '1;
                er = a;
            end else begin
                eq = a / b;
                er = a % b;
            end
            run_op("rand", a, b, eq, er);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
